// File: rtl/mac_stream_driver.sv
// Operand sequencer for a downstream MAC: buffers DEPTH signed (w, x) pairs,
// streams them one per cycle after a clear, then returns the accumulated sum.
//
// state   | meaning
// IDLE    | waiting for start, buffer writable
// CLEAR   | one-cycle accumulator clear, first pair fetched
// STREAM  | one pair per cycle with mac_en high
// CAPTURE | accumulator settled, sampled into res_data
// RESULT  | res_valid held until res_ready
module mac_stream_driver #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int WIDTH_MAC = 2 * WIDTH,
    parameter int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load_en,
    input  logic [AW-1:0]        i_load_addr,
    input  logic [WIDTH-1:0]     i_load_w,
    input  logic [WIDTH-1:0]     i_load_x,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_mac_clr,
    output logic                 o_mac_en,
    output logic [WIDTH-1:0]     o_mac_w,
    output logic [WIDTH-1:0]     o_mac_x,
    input  logic [WIDTH_MAC-1:0] i_mac_acc,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic [WIDTH_MAC-1:0] o_res_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_CAPTURE,
        S_RESULT
    } state_t;

    state_t                 r_state;
    logic [AW-1:0]          r_idx;
    logic [WIDTH-1:0]       r_buf_w [DEPTH];
    logic [WIDTH-1:0]       r_buf_x [DEPTH];
    logic                   r_mac_clr;
    logic                   r_mac_en;
    logic [WIDTH-1:0]       r_mac_w;
    logic [WIDTH-1:0]       r_mac_x;
    logic                   r_res_valid;
    logic [WIDTH_MAC-1:0]   r_res_data;

    logic                   w_load_ok;
    logic [AW-1:0]          w_idx_next;
    logic                   w_last;

    assign w_load_ok  = i_load_en && (r_state == S_IDLE) && (32'(i_load_addr) < DEPTH);
    assign w_idx_next = r_idx + 1'b1;
    assign w_last     = (r_idx == AW'(DEPTH - 1));

    assign o_busy      = (r_state != S_IDLE);
    assign o_mac_clr   = r_mac_clr;
    assign o_mac_en    = r_mac_en;
    assign o_mac_w     = r_mac_w;
    assign o_mac_x     = r_mac_x;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_w[i] <= '0;
                r_buf_x[i] <= '0;
            end
        end else if (w_load_ok) begin
            r_buf_w[i_load_addr] <= i_load_w;
            r_buf_x[i_load_addr] <= i_load_x;
        end
    end

    // Operand registers are loaded one cycle ahead so each STREAM cycle
    // presents entry[r_idx] straight from flops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_mac_clr   <= 1'b0;
            r_mac_en    <= 1'b0;
            r_mac_w     <= '0;
            r_mac_x     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state   <= S_CLEAR;
                        r_mac_clr <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state   <= S_STREAM;
                    r_mac_clr <= 1'b0;
                    r_idx     <= '0;
                    r_mac_en  <= 1'b1;
                    r_mac_w   <= r_buf_w[0];
                    r_mac_x   <= r_buf_x[0];
                end
                S_STREAM: begin
                    if (w_last) begin
                        r_state  <= S_CAPTURE;
                        r_mac_en <= 1'b0;
                        r_mac_w  <= '0;
                        r_mac_x  <= '0;
                    end else begin
                        r_idx   <= w_idx_next;
                        r_mac_w <= r_buf_w[w_idx_next];
                        r_mac_x <= r_buf_x[w_idx_next];
                    end
                end
                S_CAPTURE: begin
                    r_state     <= S_RESULT;
                    r_res_data  <= i_mac_acc;
                    r_res_valid <= 1'b1;
                end
                S_RESULT: begin
                    if (i_res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                        r_idx       <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_stream_driver.sv
// Directed bench for mac_stream_driver with a behavioural MAC on each instance
// (DEPTH=4 main instance, DEPTH=3 instance for the address bound).
module tb_mac_stream_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        load_en;
    logic [1:0]  load_addr;
    logic [7:0]  load_w, load_x;
    logic        start;
    logic        busy, mac_clr, mac_en;
    logic [7:0]  mac_w, mac_x;
    logic [15:0] mac_acc;
    logic        res_valid, res_ready;
    logic [15:0] res_data;

    logic        load_en3;
    logic [1:0]  load_addr3;
    logic [7:0]  load_w3, load_x3;
    logic        start3;
    logic        busy3, mac_clr3, mac_en3;
    logic [7:0]  mac_w3, mac_x3;
    logic [15:0] mac_acc3;
    logic        res_valid3, res_ready3;
    logic [15:0] res_data3;

    int errs   = 0;
    int checks = 0;

    mac_stream_driver #(.WIDTH(8), .DEPTH(4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_load_en(load_en), .i_load_addr(load_addr),
        .i_load_w(load_w), .i_load_x(load_x), .i_start(start), .o_busy(busy),
        .o_mac_clr(mac_clr), .o_mac_en(mac_en), .o_mac_w(mac_w), .o_mac_x(mac_x),
        .i_mac_acc(mac_acc), .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_data(res_data)
    );

    mac_stream_driver #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_load_en(load_en3), .i_load_addr(load_addr3),
        .i_load_w(load_w3), .i_load_x(load_x3), .i_start(start3), .o_busy(busy3),
        .o_mac_clr(mac_clr3), .o_mac_en(mac_en3), .o_mac_w(mac_w3), .o_mac_x(mac_x3),
        .i_mac_acc(mac_acc3), .o_res_valid(res_valid3), .i_res_ready(res_ready3),
        .o_res_data(res_data3)
    );

    // Downstream MAC model: synchronous clear has priority over enable.
    always @(posedge clk or posedge rst) begin
        if (rst)          mac_acc <= '0;
        else if (mac_clr) mac_acc <= '0;
        else if (mac_en)  mac_acc <= mac_acc + ({{8{mac_w[7]}}, mac_w} * {{8{mac_x[7]}}, mac_x});
    end

    always @(posedge clk or posedge rst) begin
        if (rst)           mac_acc3 <= '0;
        else if (mac_clr3) mac_acc3 <= '0;
        else if (mac_en3)  mac_acc3 <= mac_acc3 + ({{8{mac_w3[7]}}, mac_w3} * {{8{mac_x3[7]}}, mac_x3});
    end

    task automatic load4(input int a, input int w, input int x);
        @(negedge clk);
        load_en = 1'b1; load_addr = a[1:0]; load_w = w[7:0]; load_x = x[7:0];
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic load3(input int a, input int w, input int x);
        @(negedge clk);
        load_en3 = 1'b1; load_addr3 = a[1:0]; load_w3 = w[7:0]; load_x3 = x[7:0];
        @(negedge clk);
        load_en3 = 1'b0;
    endtask

    task automatic load_basic();
        for (int i = 0; i < 4; i++) load4(i, i + 1, i + 5);
    endtask

    // Runs one dot product on the DEPTH=4 instance with res_ready high.
    task automatic run4(output logic [15:0] data, output bit ok);
        res_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 40 && !res_valid; c++) @(negedge clk);
        ok   = res_valid;
        data = res_data;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        bit ok;
        @(negedge clk);
        rst = 1'b1;
        load_en = 1'($urandom); load_addr = 2'($urandom);
        load_w = 8'($urandom); load_x = 8'($urandom);
        start = 1'($urandom); res_ready = 1'($urandom);
        #1;
        checks++; if (busy !== 1'b0)      begin errs++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (mac_clr !== 1'b0)   begin errs++; $display("FAIL rst_clr got=%b exp=0", mac_clr); end
        checks++; if (mac_en !== 1'b0)    begin errs++; $display("FAIL rst_en got=%b exp=0", mac_en); end
        checks++; if ({mac_w, mac_x} !== 16'h0) begin errs++; $display("FAIL rst_wx got=%h exp=0000", {mac_w, mac_x}); end
        checks++; if (res_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b exp=0", res_valid); end
        checks++; if (res_data !== 16'h0) begin errs++; $display("FAIL rst_data got=%h exp=0000", res_data); end
        @(negedge clk);
        load_en = 1'b0; start = 1'b0; res_ready = 1'b1;
        rst = 1'b0;
        run4(d, ok);
        checks++; if (!ok)          begin errs++; $display("FAIL rst_run_timeout got=%b exp=1", ok); end
        checks++; if (d !== 16'h0)  begin errs++; $display("FAIL rst_run_data got=%h exp=0000", d); end
    endtask

    task automatic test_basic();
        logic [7:0] ew, ex;
        load_basic();
        res_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            ew = (c >= 2 && c <= 5) ? 8'(c - 1) : 8'd0;
            ex = (c >= 2 && c <= 5) ? 8'(c + 3) : 8'd0;
            checks++; if (mac_clr !== (c == 1))
                begin errs++; $display("FAIL basic_clr c=%0d got=%b exp=%b", c, mac_clr, (c == 1)); end
            checks++; if (mac_en !== (c >= 2 && c <= 5))
                begin errs++; $display("FAIL basic_en c=%0d got=%b exp=%b", c, mac_en, (c >= 2 && c <= 5)); end
            checks++; if (mac_w !== ew) begin errs++; $display("FAIL basic_w c=%0d got=%0d exp=%0d", c, mac_w, ew); end
            checks++; if (mac_x !== ex) begin errs++; $display("FAIL basic_x c=%0d got=%0d exp=%0d", c, mac_x, ex); end
            checks++; if (res_valid !== (c == 7))
                begin errs++; $display("FAIL basic_valid c=%0d got=%b exp=%b", c, res_valid, (c == 7)); end
            checks++; if (busy !== (c <= 7))
                begin errs++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, busy, (c <= 7)); end
            if (c == 7) begin
                checks++; if (res_data !== 16'd70) begin errs++; $display("FAIL basic_data got=%0d exp=70", res_data); end
            end
        end
    endtask

    task automatic test_signed();
        logic [15:0] d;
        bit ok;
        for (int i = 0; i < 4; i++) load4(i, -1, 3);
        run4(d, ok);
        checks++; if (!ok || d !== 16'hFFF4) begin errs++; $display("FAIL signed_neg got=%h ok=%b exp=fff4", d, ok); end
        for (int i = 0; i < 4; i++) load4(i, -128, -128);
        run4(d, ok);
        checks++; if (!ok || d !== 16'h0000) begin errs++; $display("FAIL signed_wrap got=%h ok=%b exp=0000", d, ok); end
    endtask

    task automatic test_backpressure();
        logic [15:0] d;
        bit ok;
        int cyc;
        load_basic();
        res_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        while (!res_valid && cyc < 40) begin @(negedge clk); cyc++; end
        checks++; if (cyc !== 7) begin errs++; $display("FAIL bp_latency got=%0d exp=7", cyc); end
        for (int k = 0; k < 5; k++) begin
            start = 1'b1; load_en = 1'b1; load_addr = 2'd0; load_w = 8'd99; load_x = 8'd99;
            @(negedge clk);
            checks++; if (res_valid !== 1'b1) begin errs++; $display("FAIL bp_valid k=%0d got=%b exp=1", k, res_valid); end
            checks++; if (res_data !== 16'd70) begin errs++; $display("FAIL bp_data k=%0d got=%0d exp=70", k, res_data); end
            checks++; if (mac_en !== 1'b0) begin errs++; $display("FAIL bp_en k=%0d got=%b exp=0", k, mac_en); end
        end
        start = 1'b0; load_en = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errs++; $display("FAIL bp_xfer_valid got=%b exp=0", res_valid); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL bp_idle_busy got=%b exp=0", busy); end
        run4(d, ok);
        checks++; if (!ok || d !== 16'd70) begin errs++; $display("FAIL bp_buffer got=%0d ok=%b exp=70", d, ok); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        bit ok;
        res_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mac_en !== 1'b1) begin errs++; $display("FAIL mid_pre_en got=%b exp=1", mac_en); end
        rst = 1'b1;
        #1;
        checks++; if ({busy, mac_clr, mac_en, res_valid} !== 4'b0)
            begin errs++; $display("FAIL mid_ctrl got=%b exp=0000", {busy, mac_clr, mac_en, res_valid}); end
        checks++; if ({mac_w, mac_x, res_data} !== 32'h0)
            begin errs++; $display("FAIL mid_data got=%h exp=00000000", {mac_w, mac_x, res_data}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_idle got=%b exp=0", busy); end
        run4(d, ok);
        checks++; if (!ok || d !== 16'h0) begin errs++; $display("FAIL mid_cleared got=%0d ok=%b exp=0", d, ok); end
        load_basic();
        run4(d, ok);
        checks++; if (!ok || d !== 16'd70) begin errs++; $display("FAIL mid_reload got=%0d ok=%b exp=70", d, ok); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        res_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        checks++; if (res_valid !== 1'b1 || res_data !== 16'd70)
            begin errs++; $display("FAIL b2b_first got=%0d valid=%b exp=70", res_data, res_valid); end
        // entry0 write held over the handshake edge: dropped there, taken in IDLE
        start = 1'b1; load_en = 1'b1; load_addr = 2'd0; load_w = 8'd10; load_x = 8'd5;
        @(negedge clk);
        checks++; if ({res_valid, busy, mac_clr} !== 3'b000)
            begin errs++; $display("FAIL b2b_gap got=%b exp=000", {res_valid, busy, mac_clr}); end
        @(negedge clk);
        start = 1'b0; load_en = 1'b0;
        checks++; if (mac_clr !== 1'b1) begin errs++; $display("FAIL b2b_clr got=%b exp=1", mac_clr); end
        cyc = 9;
        while (!res_valid && cyc < 60) begin @(negedge clk); cyc++; end
        checks++; if (cyc !== 15) begin errs++; $display("FAIL b2b_latency got=%0d exp=15", cyc); end
        checks++; if (res_data !== 16'd115) begin errs++; $display("FAIL b2b_second got=%0d exp=115", res_data); end
        @(negedge clk);
    endtask

    task automatic test_depth3_bound();
        int cyc;
        load3(0, 2, 1);
        load3(1, 3, 1);
        load3(2, 4, 1);
        load3(3, 100, 100);
        res_ready3 = 1'b1;
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        cyc = 1;
        while (!res_valid3 && cyc < 40) begin @(negedge clk); cyc++; end
        checks++; if (cyc !== 6) begin errs++; $display("FAIL d3_latency got=%0d exp=6", cyc); end
        checks++; if (res_data3 !== 16'd9) begin errs++; $display("FAIL d3_data got=%0d exp=9", res_data3); end
        @(negedge clk);
        checks++; if (busy3 !== 1'b0) begin errs++; $display("FAIL d3_idle got=%b exp=0", busy3); end
    endtask

    initial begin
        rst = 1'b1;
        load_en = 1'b0; load_addr = '0; load_w = '0; load_x = '0; start = 1'b0; res_ready = 1'b1;
        load_en3 = 1'b0; load_addr3 = '0; load_w3 = '0; load_x3 = '0; start3 = 1'b0; res_ready3 = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_depth3_bound();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
